// File: rtl/mips_pipeline_top.sv
// Five-stage pipelined 32-bit MIPS core (IF/ID/EX/MEM/WB) with full forwarding,
// load-use interlock, jumps resolved in ID and branches/jr resolved in EX.
module mips_pipeline_top (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Memory_out,
    input  logic [31:0] Inst_out,
    output logic [31:0] Pc_out,
    output logic [31:0] Ex_Mem_out3,
    output logic [31:0] Ex_Mem_out4,
    output logic        Memread,
    output logic        Memwrite
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LINK} alu_op_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       jump_reg;
        logic       alu_src;   // second ALU operand is the immediate
        alu_op_t    alu_op;
        logic [4:0] dest;
    } ctrl_t;

    // Architectural and pipeline state
    logic [31:0] pc;
    logic [31:0] regs [32];
    logic [31:0] if_id_inst, if_id_pc1;
    ctrl_t       id_ex_ctrl;
    logic [4:0]  id_ex_rs, id_ex_rt;
    logic [31:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_pc1;
    logic        ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
    logic [4:0]  ex_mem_dest;
    logic [31:0] ex_mem_result, ex_mem_store;
    logic        mem_wb_reg_write, mem_wb_mem_read;
    logic [4:0]  mem_wb_dest;
    logic [31:0] mem_wb_result, mem_wb_mem_data;

    // ID-stage fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    assign opcode = if_id_inst[31:26];
    assign rs     = if_id_inst[25:21];
    assign rt     = if_id_inst[20:16];
    assign rd     = if_id_inst[15:11];
    assign funct  = if_id_inst[5:0];

    ctrl_t id_ctrl;
    logic  uses_rs, uses_rt, id_jump, imm_zext;

    // Instruction decode into control bundle and operand-use flags
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        id_ctrl  = '0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        id_jump  = 1'b0;
        imm_zext = 1'b0;
        case (opcode)
            6'h00: begin
                id_ctrl.dest = rd;
                uses_rs      = 1'b1;
                uses_rt      = 1'b1;
                case (funct)
                    6'h20: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_ADD; end
                    6'h22: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_SUB; end
                    6'h24: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_AND; end
                    6'h25: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_OR;  end
                    6'h2A: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_SLT; end
                    6'h08: begin id_ctrl.jump_reg  = 1'b1; uses_rt = 1'b0; end
                    default: begin uses_rs = 1'b0; uses_rt = 1'b0; end
                endcase
            end
            6'h08: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_src = 1'b1; id_ctrl.dest = rt; uses_rs = 1'b1; end
            6'h0C: begin
                id_ctrl.reg_write = 1'b1; id_ctrl.alu_src = 1'b1; id_ctrl.dest = rt;
                id_ctrl.alu_op = ALU_AND; uses_rs = 1'b1; imm_zext = 1'b1;
            end
            6'h0A: begin
                id_ctrl.reg_write = 1'b1; id_ctrl.alu_src = 1'b1; id_ctrl.dest = rt;
                id_ctrl.alu_op = ALU_SLT; uses_rs = 1'b1;
            end
            6'h23: begin
                id_ctrl.reg_write = 1'b1; id_ctrl.mem_read = 1'b1; id_ctrl.alu_src = 1'b1;
                id_ctrl.dest = rt; uses_rs = 1'b1;
            end
            6'h2B: begin id_ctrl.mem_write = 1'b1; id_ctrl.alu_src = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            6'h04: begin id_ctrl.branch_eq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            6'h05: begin id_ctrl.branch_ne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            6'h02: id_jump = 1'b1;
            6'h03: begin
                id_jump = 1'b1; id_ctrl.reg_write = 1'b1; id_ctrl.dest = 5'd31; id_ctrl.alu_op = ALU_LINK;
            end
            default: ;
        endcase
    end

    // Register read with write-then-read bypass from WB
    logic [31:0] wb_data, rs_val, rt_val, id_imm, jump_target;
    logic        wb_en;
    assign wb_data     = mem_wb_mem_read ? mem_wb_mem_data : mem_wb_result;
    assign wb_en       = mem_wb_reg_write && (mem_wb_dest != 5'd0);
    assign rs_val      = (wb_en && mem_wb_dest == rs) ? wb_data : regs[rs];
    assign rt_val      = (wb_en && mem_wb_dest == rt) ? wb_data : regs[rt];
    assign id_imm      = imm_zext ? {16'h0000, if_id_inst[15:0]} : {{16{if_id_inst[15]}}, if_id_inst[15:0]};
    assign jump_target = {if_id_pc1[31:26], if_id_inst[25:0]};

    // Forwarding: EX/MEM beats MEM/WB beats the value read in ID; $0 is never forwarded
    logic        fwd_mem_a, fwd_mem_b;
    logic [31:0] alu_a, fwd_b, alu_b, alu_result, branch_target;
    logic        branch_taken, load_use;
    assign fwd_mem_a = ex_mem_reg_write && (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rs);
    assign fwd_mem_b = ex_mem_reg_write && (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rt);
    assign alu_a = fwd_mem_a ? ex_mem_result :
                   (wb_en && mem_wb_dest == id_ex_rs) ? wb_data : id_ex_a;
    assign fwd_b = fwd_mem_b ? ex_mem_result :
                   (wb_en && mem_wb_dest == id_ex_rt) ? wb_data : id_ex_b;
    assign alu_b = id_ex_ctrl.alu_src ? id_ex_imm : fwd_b;

    // Execute-stage ALU
    always_comb begin
        case (id_ex_ctrl.alu_op)
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_AND:  alu_result = alu_a & alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_SLT:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            ALU_LINK: alu_result = id_ex_pc1;
            default:  alu_result = alu_a + alu_b;
        endcase
    end

    assign branch_taken  = (id_ex_ctrl.branch_eq && (alu_a == fwd_b)) ||
                           (id_ex_ctrl.branch_ne && (alu_a != fwd_b)) || id_ex_ctrl.jump_reg;
    assign branch_target = id_ex_ctrl.jump_reg ? alu_a : id_ex_pc1 + id_ex_imm;
    assign load_use      = id_ex_ctrl.mem_read && (id_ex_ctrl.dest != 5'd0) &&
                           ((uses_rs && id_ex_ctrl.dest == rs) || (uses_rt && id_ex_ctrl.dest == rt));

    // Front end: PC and IF/ID, with branch flush overriding stall and jump
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            pc <= '0; if_id_inst <= '0; if_id_pc1 <= '0;
        end else if (branch_taken) begin
            pc <= branch_target; if_id_inst <= '0; if_id_pc1 <= '0;
        end else if (load_use) begin
            pc <= pc;
        end else if (id_jump) begin
            pc <= jump_target; if_id_inst <= '0; if_id_pc1 <= '0;
        end else begin
            pc <= pc + 32'd1; if_id_inst <= Inst_out; if_id_pc1 <= pc + 32'd1;
        end
    end

    // ID/EX register; a bubble on reset, taken branch or load-use stall
    always_ff @(posedge clk) begin
        if (rst || branch_taken || load_use) begin
            id_ex_ctrl <= '0; id_ex_rs <= '0; id_ex_rt <= '0;
            id_ex_a <= '0; id_ex_b <= '0; id_ex_imm <= '0; id_ex_pc1 <= '0;
        end else begin
            id_ex_ctrl <= id_ctrl; id_ex_rs <= rs; id_ex_rt <= rt;
            id_ex_a <= rs_val; id_ex_b <= rt_val; id_ex_imm <= id_imm; id_ex_pc1 <= if_id_pc1;
        end
    end

    // EX/MEM and MEM/WB registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_reg_write <= 1'b0; ex_mem_mem_read <= 1'b0; ex_mem_mem_write <= 1'b0;
            ex_mem_dest <= '0; ex_mem_result <= '0; ex_mem_store <= '0;
            mem_wb_reg_write <= 1'b0; mem_wb_mem_read <= 1'b0; mem_wb_dest <= '0;
            mem_wb_result <= '0; mem_wb_mem_data <= '0;
        end else begin
            ex_mem_reg_write <= id_ex_ctrl.reg_write; ex_mem_mem_read <= id_ex_ctrl.mem_read;
            ex_mem_mem_write <= id_ex_ctrl.mem_write; ex_mem_dest <= id_ex_ctrl.dest;
            ex_mem_result <= alu_result; ex_mem_store <= fwd_b;
            mem_wb_reg_write <= ex_mem_reg_write; mem_wb_mem_read <= ex_mem_mem_read;
            mem_wb_dest <= ex_mem_dest; mem_wb_result <= ex_mem_result; mem_wb_mem_data <= Memory_out;
        end
    end

    // Register file write port; cleared on reset, $0 stays zero
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is a memory that is explicitly cleared so reads after reset are defined.
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[mem_wb_dest] <= wb_data;
        end
    end

    assign Pc_out      = pc;
    assign Ex_Mem_out3 = ex_mem_result;
    assign Ex_Mem_out4 = ex_mem_store;
    assign Memread     = ex_mem_mem_read;
    assign Memwrite    = ex_mem_mem_write;
endmodule

// File: tb/tb_mips_pipeline_top.sv
// Testbench for mips_pipeline_top: a directed program with cycle-level timing checks,
// then random programs compared against an instruction-level reference interpreter.
module tb_mips_pipeline_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Memory_out, Inst_out, Pc_out, Ex_Mem_out3, Ex_Mem_out4;
    logic        Memread, Memwrite;

    logic [31:0] imem     [256];
    logic [31:0] dmem     [2048];
    logic [31:0] init_mem [2048];
    logic [31:0] m_mem    [2048];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    logic [31:0] pc_trace [400];
    logic [31:0] addr_trace [400];
    logic        rd_trace [400];
    logic        wr_trace [400];
    int          n_checks = 0;
    int          n_fail   = 0;

    mips_pipeline_top dut (
        .clk(clk), .rst(rst), .Memory_out(Memory_out), .Inst_out(Inst_out),
        .Pc_out(Pc_out), .Ex_Mem_out3(Ex_Mem_out3), .Ex_Mem_out4(Ex_Mem_out4),
        .Memread(Memread), .Memwrite(Memwrite)
    );

    always #5 clk = ~clk;

    assign Inst_out   = imem[Pc_out[7:0]];
    assign Memory_out = dmem[Ex_Mem_out3[10:0]];

    // Data memory: preloaded during reset, written on the edge after Memwrite
    always @(posedge clk) begin
        if (rst) dmem <= init_mem;
        else if (Memwrite) dmem[Ex_Mem_out3[10:0]] <= Ex_Mem_out4;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    // Instruction-level interpreter: no pipeline, one instruction per step
    task automatic run_model(input logic [31:0] halt_pc);
        logic [31:0] r [32];
        logic [31:0] pc, ins, a, b, sx, zx, nxt, addr, wv;
        logic [4:0]  wd;
        logic        we;
        int          steps;
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        for (int i = 0; i < 2048; i++) m_mem[i] = init_mem[i];
        exp_addr.delete();
        exp_data.delete();
        pc = 32'd0;
        steps = 0;
        while (pc != halt_pc) begin
            if (steps > 2000) begin
                $display("FAIL model_runaway: got pc %0d expected halt %0d", pc, halt_pc);
                $fatal(1, "reference program did not halt");
            end
            steps++;
            ins = imem[pc[7:0]];
            a   = r[ins[25:21]];
            b   = r[ins[20:16]];
            sx  = {{16{ins[15]}}, ins[15:0]};
            zx  = {16'h0000, ins[15:0]};
            nxt = pc + 1;
            we  = 1'b0; wd = 5'd0; wv = 32'd0;
            case (ins[31:26])
                6'h00: begin
                    wd = ins[15:11]; we = 1'b1;
                    case (ins[5:0])
                        6'h20: wv = a + b;
                        6'h22: wv = a - b;
                        6'h24: wv = a & b;
                        6'h25: wv = a | b;
                        6'h2A: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h08: begin we = 1'b0; nxt = a; end
                        default: we = 1'b0;
                    endcase
                end
                6'h08: begin we = 1'b1; wd = ins[20:16]; wv = a + sx; end
                6'h0C: begin we = 1'b1; wd = ins[20:16]; wv = a & zx; end
                6'h0A: begin we = 1'b1; wd = ins[20:16]; wv = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
                6'h23: begin addr = a + sx; we = 1'b1; wd = ins[20:16]; wv = m_mem[addr[10:0]]; end
                6'h2B: begin
                    addr = a + sx;
                    m_mem[addr[10:0]] = b;
                    exp_addr.push_back(addr);
                    exp_data.push_back(b);
                end
                6'h04: if (a == b) nxt = pc + 1 + sx;
                6'h05: if (a != b) nxt = pc + 1 + sx;
                6'h02: nxt = {nxt[31:26], ins[25:0]};
                6'h03: begin we = 1'b1; wd = 5'd31; wv = pc + 1; nxt = {nxt[31:26], ins[25:0]}; end
                default: ;
            endcase
            if (we && wd != 5'd0) r[wd] = wv;
            pc = nxt;
        end
    endtask

    // Reset the core, then run a fixed cycle budget recording outputs and checking stores in order
    task automatic run_dut(input int cycles);
        int seen;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_pc", Pc_out, 32'd0);
        check("reset_memread", {31'b0, Memread}, 32'd0);
        check("reset_memwrite", {31'b0, Memwrite}, 32'd0);
        check("reset_addr", Ex_Mem_out3, 32'd0);
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            if (c > 0) @(negedge clk);
            pc_trace[c]   = Pc_out;
            addr_trace[c] = Ex_Mem_out3;
            rd_trace[c]   = Memread;
            wr_trace[c]   = Memwrite;
            if (Memwrite) begin
                if (seen < exp_addr.size()) begin
                    check($sformatf("store%0d_addr", seen), Ex_Mem_out3, exp_addr[seen]);
                    check($sformatf("store%0d_data", seen), Ex_Mem_out4, exp_data[seen]);
                end else begin
                    check("store_overflow", seen + 1, exp_addr.size());
                end
                seen++;
            end
        end
        check("store_count", seen, exp_addr.size());
    endtask

    task automatic compare_mem(input logic [31:0] halt_pc);
        @(negedge clk);
        for (int i = 1000; i < 1128; i++) check($sformatf("mem_%0d", i), dmem[i], m_mem[i]);
        check("halt_pc", {31'b0, (Pc_out == halt_pc) || (Pc_out == halt_pc + 1)}, 32'd1);
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
        for (int i = 0; i < 2048; i++) init_mem[i] = 32'd0;
    endtask

    // Random straight-line body with forward-only branches/jumps, then a register dump and halt
    task automatic gen_random(output logic [31:0] halt_pc);
        int body;
        body = 40;
        clear_mems();
        for (int i = 1000; i < 1016; i++) init_mem[i] = $urandom;
        for (int i = 0; i < body; i++) begin
            int         k;
            int         off;
            logic [4:0] s, t, d;
            k   = $urandom_range(0, 13);
            s   = 5'($urandom_range(0, 7));
            t   = 5'($urandom_range(0, 7));
            d   = 5'($urandom_range(0, 7));
            off = $urandom_range(0, 3);
            if (i + 1 + off > body) off = body - (i + 1);
            case (k)
                0:  imem[i] = r_type(6'h20, s, t, d);
                1:  imem[i] = r_type(6'h22, s, t, d);
                2:  imem[i] = r_type(6'h24, s, t, d);
                3:  imem[i] = r_type(6'h25, s, t, d);
                4:  imem[i] = r_type(6'h2A, s, t, d);
                5:  imem[i] = i_type(6'h08, s, t, 16'($urandom));
                6:  imem[i] = i_type(6'h0C, s, t, 16'($urandom));
                7:  imem[i] = i_type(6'h0A, s, t, 16'($urandom));
                8, 9: imem[i] = i_type(6'h23, 5'd0, t, 16'(1000 + $urandom_range(0, 15)));
                10: imem[i] = i_type(6'h2B, 5'd0, t, 16'(1000 + $urandom_range(0, 15)));
                11: imem[i] = i_type(6'h04, s, t, 16'(off));
                12: imem[i] = i_type(6'h05, s, t, 16'(off));
                default: imem[i] = j_type(6'h02, 26'(i + 1 + off));
            endcase
        end
        for (int r = 1; r < 8; r++) imem[body + r - 1] = i_type(6'h2B, 5'd0, 5'(r), 16'(1100 + r));
        halt_pc = 32'(body + 7);
        imem[halt_pc[7:0]] = j_type(6'h02, 26'(halt_pc));
    endtask

    initial begin
        logic [31:0] halt_pc;

        // Directed program: forwarding, load-use, stores, taken beq, jal/jr
        clear_mems();
        init_mem[1000] = 32'd7;
        imem[0]  = i_type(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1]  = i_type(6'h08, 5'd1, 5'd2, 16'd3);
        imem[2]  = r_type(6'h20, 5'd1, 5'd2, 5'd3);
        imem[3]  = i_type(6'h23, 5'd0, 5'd4, 16'd1000);
        imem[4]  = r_type(6'h20, 5'd4, 5'd4, 5'd5);
        imem[5]  = i_type(6'h2B, 5'd0, 5'd5, 16'd1001);
        imem[6]  = i_type(6'h2B, 5'd0, 5'd3, 16'd1002);
        imem[7]  = i_type(6'h04, 5'd1, 5'd1, 16'd2);
        imem[8]  = i_type(6'h08, 5'd0, 5'd6, 16'd99);
        imem[9]  = i_type(6'h2B, 5'd0, 5'd1, 16'd1003);
        imem[10] = j_type(6'h03, 26'd20);
        imem[11] = i_type(6'h2B, 5'd0, 5'd31, 16'd1004);
        imem[12] = j_type(6'h02, 26'd12);
        imem[20] = i_type(6'h2B, 5'd0, 5'd31, 16'd1005);
        imem[21] = r_type(6'h08, 5'd31, 5'd0, 5'd0);
        halt_pc = 32'd12;
        run_model(halt_pc);
        run_dut(60);
        check("seq_pc1", pc_trace[1], 32'd1);
        check("seq_pc2", pc_trace[2], 32'd2);
        check("seq_pc3", pc_trace[3], 32'd3);
        check("stall_pc_c5", pc_trace[5], 32'd5);
        check("stall_pc_c6", pc_trace[6], 32'd5);
        check("stall_pc_c7", pc_trace[7], 32'd6);
        check("lw_memread", {31'b0, rd_trace[6]}, 32'd1);
        check("lw_addr", addr_trace[6], 32'd1000);
        check("sw_before", {31'b0, wr_trace[8]}, 32'd0);
        check("sw_memwrite", {31'b0, wr_trace[9]}, 32'd1);
        check("sw_addr", addr_trace[9], 32'd1001);
        check("beq_pc_c10", pc_trace[10], 32'd9);
        check("beq_target", pc_trace[11], 32'd10);
        check("jal_slot", pc_trace[12], 32'd11);
        check("jal_target", pc_trace[13], 32'd20);
        check("exp_sw5", m_mem[1001], 32'd14);
        compare_mem(halt_pc);

        // Random programs against the interpreter
        for (int p = 0; p < 8; p++) begin
            gen_random(halt_pc);
            run_model(halt_pc);
            run_dut(300);
            compare_mem(halt_pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
